cpu_multiply_seq: RTL and testbench

Parametrised, iterative integer multiplier for the CPU execute stage, successor to the single-cycle signed/unsigned multiply unit. Supports all four RV32M multiply modes (MUL, MULH, MULHSU, MULHU) with independent per-operand signedness. Retires BITS_PER_CYCLE multiplier bits per clock and uses a valid/ready handshake toward the pipeline. Returns the full 2*WIDTH product plus the mode-selected WIDTH-bit word.

---
 rtl/cpu_multiply_pkg.sv | 24 ++
 rtl/cpu_multiply_seq_if.sv | 23 ++
 rtl/cpu_multiply_step.sv | 20 ++
 rtl/cpu_multiply_seq.sv | 106 ++++++++++
 tb/tb_cpu_multiply_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_multiply_pkg.sv
// Shared encodings for the iterative multiplier: op modes, FSM states, signedness helpers.
package cpu_multiply_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // rs1 is signed for MULH and MULHSU
    function automatic logic op_signed1(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    // rs2 is signed only for MULH
    function automatic logic op_signed2(input logic [1:0] op);
        return op == MUL_OP_MULH;
    endfunction

endpackage

// File: rtl/cpu_multiply_seq_if.sv
// Request/response bundle between the execute pipeline and the multiplier.
interface cpu_multiply_seq_if #(
    parameter int WIDTH = 32
);
    logic                 i_valid;
    logic                 o_ready;
    logic [1:0]           i_op;
    logic [WIDTH-1:0]     i_op1;
    logic [WIDTH-1:0]     i_op2;
    logic                 o_valid;
    logic [2*WIDTH-1:0]   o_result;
    logic [WIDTH-1:0]     o_word;

    modport master (
        output i_valid, i_op, i_op1, i_op2,
        input  o_ready, o_valid, o_result, o_word
    );

    modport slave (
        input  i_valid, i_op, i_op1, i_op2,
        output o_ready, o_valid, o_result, o_word
    );
endinterface

// File: rtl/cpu_multiply_step.sv
// One RUN step: BITS_PER_CYCLE multiplier bits times the multiplicand, added at its weight.
module cpu_multiply_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int CW             = 6
) (
    input  logic [WIDTH-1:0]          mcand,
    input  logic [BITS_PER_CYCLE-1:0] mbits,
    input  logic [CW-1:0]             count,
    input  logic [2*WIDTH-1:0]        acc_in,
    output logic [2*WIDTH-1:0]        acc_out
);
    logic [2*WIDTH-1:0] partial;

    // Partial product in full product width so the shifted add never truncates
    always_comb begin
        partial = {{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, mbits};
        acc_out = acc_in + (partial << (int'(count) * BITS_PER_CYCLE));
    end
endmodule

// File: rtl/cpu_multiply_seq.sv
// Iterative RV32M-style multiplier: magnitudes multiplied over WIDTH/BITS_PER_CYCLE
// cycles, sign restored in a final FIX cycle.
module cpu_multiply_seq
    import cpu_multiply_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic               i_clock,
    input logic               i_reset_n,
    cpu_multiply_seq_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
        $error("cpu_multiply_seq: WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic               neg;
    logic [WIDTH-1:0]   m1;
    logic [WIDTH-1:0]   m2;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] product;
    logic               sign1;
    logic               sign2;
    logic [WIDTH-1:0]   m1_in;
    logic [WIDTH-1:0]   m2_in;
    logic               accept;

    assign bus.o_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign accept      = bus.o_ready && bus.i_valid;

    // Operand magnitudes from the live request; -2^(W-1) maps onto 2^(W-1) unsigned
    always_comb begin
        sign1 = op_signed1(bus.i_op) && bus.i_op1[WIDTH-1];
        sign2 = op_signed2(bus.i_op) && bus.i_op2[WIDTH-1];
        m1_in = sign1 ? -bus.i_op1 : bus.i_op1;
        m2_in = sign2 ? -bus.i_op2 : bus.i_op2;
    end

    cpu_multiply_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .CW             (CW)
    ) u_step (
        .mcand   (m1),
        .mbits   (m2[BITS_PER_CYCLE-1:0]),
        .count   (count),
        .acc_in  (acc),
        .acc_out (acc_next)
    );

    assign product = neg ? -acc : acc;

    // Control FSM, operand latches, accumulator and held result registers
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state        <= ST_IDLE;
            op_q         <= MUL_OP_MUL;
            neg          <= 1'b0;
            m1           <= '0;
            m2           <= '0;
            count        <= '0;
            acc          <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_result <= '0;
            bus.o_word   <= '0;
        end else begin
            bus.o_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        m1    <= m1_in;
                        m2    <= m2_in;
                        neg   <= sign1 ^ sign2;
                        op_q  <= bus.i_op;
                        acc   <= '0;
                        count <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    m2    <= m2 >> BITS_PER_CYCLE;
                    count <= count + CW'(1);
                    if (count == CW'(N - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    bus.o_result <= product;
                    bus.o_word   <= (op_q == MUL_OP_MUL) ? product[WIDTH-1:0]
                                                         : product[2*WIDTH-1:WIDTH];
                    bus.o_valid  <= 1'b1;
                    state        <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multiply_seq.sv
// Scoreboard bench: four multipliers with BITS_PER_CYCLE 1/2/4/8 sharing clock and reset.
module tb_cpu_multiply_seq;

    typedef struct packed {
        logic [63:0] res;
        logic [31:0] word;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vld [4];
    logic [1:0]  op  [4];
    logic [31:0] a   [4];
    logic [31:0] b   [4];
    logic        rdy [4];
    logic        ov  [4];
    logic [63:0] res [4];
    logic [31:0] wrd [4];

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        cpu_multiply_seq_if #(.WIDTH(32)) mbus ();
        assign mbus.i_valid = vld[g];
        assign mbus.i_op    = op[g];
        assign mbus.i_op1   = a[g];
        assign mbus.i_op2   = b[g];
        assign rdy[g]       = mbus.o_ready;
        assign ov[g]        = mbus.o_valid;
        assign res[g]       = mbus.o_result;
        assign wrd[g]       = mbus.o_word;

        cpu_multiply_seq #(.WIDTH(32), .BITS_PER_CYCLE(1 << g)) dut (
            .i_clock   (clk),
            .i_reset_n (rst_n),
            .bus       (mbus)
        );
    end

    // Reference: sign/zero extend to 64 bits and multiply
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey, p;
        exp_t e;
        ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'h0, x};
        ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'h0, y};
        p  = ex * ey;
        e.res  = p;
        e.word = (o == 2'b00) ? p[31:0] : p[63:32];
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Present one request for one edge; caller guarantees o_ready
    task automatic issue(input int k, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input exp_t e, input bit push);
        vld[k] = 1'b1; op[k] = o; a[k] = x; b[k] = y;
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        vld[k] = 1'b0;
    endtask

    // Count edges until o_valid; -1 when the bound expires
    task automatic wait_out(input int k, input int start, output int lat);
        lat = start;
        while (ov[k] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (ov[k] !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            total++; if (rdy[k] !== 1'b1)  begin bad++; $display("FAIL reset_ready[%0d] got %b want 1", k, rdy[k]); end
            total++; if (ov[k]  !== 1'b0)  begin bad++; $display("FAIL reset_valid[%0d] got %b want 0", k, ov[k]); end
            total++; if (res[k] !== 64'h0) begin bad++; $display("FAIL reset_result[%0d] got %h want 0", k, res[k]); end
            total++; if (wrd[k] !== 32'h0) begin bad++; $display("FAIL reset_word[%0d] got %h want 0", k, wrd[k]); end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        logic [1:0]  t_op  [4];
        logic [31:0] t_a   [4];
        logic [31:0] t_b   [4];
        logic [63:0] t_res [4];
        logic [31:0] t_wrd [4];
        exp_t e;
        int lat;
        // MUL treats both operands as unsigned, so the upper half is the unsigned product
        t_op[0] = 2'b00; t_a[0] = 32'd7;        t_b[0] = 32'hFFFFFFFD; t_res[0] = 64'h00000006_FFFFFFEB; t_wrd[0] = 32'hFFFFFFEB;
        t_op[1] = 2'b01; t_a[1] = 32'h80000000; t_b[1] = 32'h80000000; t_res[1] = 64'h40000000_00000000; t_wrd[1] = 32'h40000000;
        t_op[2] = 2'b11; t_a[2] = 32'hFFFFFFFF; t_b[2] = 32'hFFFFFFFF; t_res[2] = 64'hFFFFFFFE_00000001; t_wrd[2] = 32'hFFFFFFFE;
        t_op[3] = 2'b10; t_a[3] = 32'hFFFFFFFF; t_b[3] = 32'hFFFFFFFF; t_res[3] = 64'hFFFFFFFF_00000001; t_wrd[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            e.res = t_res[i]; e.word = t_wrd[i];
            issue(0, t_op[i], t_a[i], t_b[i], e, 1'b1);
            wait_out(0, 0, lat);
            e = exp_q.pop_front();
            total++; if (lat != 33)        begin bad++; $display("FAIL modes_latency[%0d] got %0d want 33", i, lat); end
            total++; if (res[0] !== e.res)  begin bad++; $display("FAIL modes_result[%0d] got %h want %h", i, res[0], e.res); end
            total++; if (wrd[0] !== e.word) begin bad++; $display("FAIL modes_word[%0d] got %h want %h", i, wrd[0], e.word); end
            @(posedge clk); #1;
            total++; if (ov[0] !== 1'b0)   begin bad++; $display("FAIL modes_pulse[%0d] got %b want 0", i, ov[0]); end
        end
    endtask

    task automatic test_bpc4();
        exp_t e;
        int lat;
        e.res = 64'hFFFFFFFF_00000001; e.word = 32'hFFFFFFFF;
        issue(2, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, e, 1'b1);
        wait_out(2, 0, lat);
        e = exp_q.pop_front();
        total++; if (lat != 9)         begin bad++; $display("FAIL bpc4_latency got %0d want 9", lat); end
        total++; if (res[2] !== e.res)  begin bad++; $display("FAIL bpc4_result got %h want %h", res[2], e.res); end
        total++; if (wrd[2] !== e.word) begin bad++; $display("FAIL bpc4_word got %h want %h", wrd[2], e.word); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_b2b();
        exp_t e, first;
        int lat;
        bit held;
        e.res = 64'd3000000; e.word = 32'h0;
        issue(0, 2'b11, 32'd1000, 32'd3000, e, 1'b1);
        // Busy-period requests with different operands must be dropped
        for (int i = 0; i < 10; i++) begin
            vld[0] = 1'b1; op[0] = 2'b01; a[0] = $urandom; b[0] = $urandom;
            total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL busy_ready[%0d] got %b want 0", i, rdy[0]); end
            @(posedge clk); #1;
        end
        vld[0] = 1'b0;
        wait_out(0, 10, lat);
        first = exp_q.pop_front();
        total++; if (lat != 33)             begin bad++; $display("FAIL ignore_latency got %0d want 33", lat); end
        total++; if (res[0] !== first.res)  begin bad++; $display("FAIL ignore_result got %h want %h", res[0], first.res); end
        total++; if (wrd[0] !== first.word) begin bad++; $display("FAIL ignore_word got %h want %h", wrd[0], first.word); end
        // Second request in the o_valid cycle
        total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b want 1", rdy[0]); end
        e.res = 64'd30; e.word = 32'd30;
        issue(0, 2'b00, 32'd5, 32'd6, e, 1'b1);
        held = 1'b1;
        lat  = 0;
        while (ov[0] !== 1'b1 && lat < 200) begin
            if (res[0] !== first.res || wrd[0] !== first.word) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (ov[0] !== 1'b1) lat = -1;
        e = exp_q.pop_front();
        total++; if (!held)            begin bad++; $display("FAIL b2b_hold got changed want %h", first.res); end
        total++; if (lat != 33)        begin bad++; $display("FAIL b2b_latency got %0d want 33", lat); end
        total++; if (res[0] !== e.res)  begin bad++; $display("FAIL b2b_result got %h want %h", res[0], e.res); end
        total++; if (wrd[0] !== e.word) begin bad++; $display("FAIL b2b_word got %h want %h", wrd[0], e.word); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int lat;
        bit seen;
        e.res = 64'h0; e.word = 32'h0;
        issue(0, 2'b01, 32'h12345678, 32'h9ABCDEF0, e, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (rdy[0] !== 1'b1)  begin bad++; $display("FAIL midrst_ready got %b want 1", rdy[0]); end
        total++; if (ov[0]  !== 1'b0)  begin bad++; $display("FAIL midrst_valid got %b want 0", ov[0]); end
        total++; if (res[0] !== 64'h0) begin bad++; $display("FAIL midrst_result got %h want 0", res[0]); end
        total++; if (wrd[0] !== 32'h0) begin bad++; $display("FAIL midrst_word got %h want 0", wrd[0]); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ov[0] === 1'b1) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL midrst_no_valid got 1 want 0"); end
        // -7 * 3 signed
        e.res = 64'hFFFFFFFF_FFFFFFEB; e.word = 32'hFFFFFFFF;
        issue(0, 2'b01, 32'hFFFFFFF9, 32'd3, e, 1'b1);
        wait_out(0, 0, lat);
        e = exp_q.pop_front();
        total++; if (lat != 33)        begin bad++; $display("FAIL postrst_latency got %0d want 33", lat); end
        total++; if (res[0] !== e.res)  begin bad++; $display("FAIL postrst_result got %h want %h", res[0], e.res); end
        total++; if (wrd[0] !== e.word) begin bad++; $display("FAIL postrst_word got %h want %h", wrd[0], e.word); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        exp_t e;
        int lat;
        logic [1:0]  o;
        logic [31:0] x, y;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 400; n++) begin
                o = 2'($urandom_range(0, 3));
                x = pick();
                y = pick();
                issue(k, o, x, y, model(o, x, y), 1'b1);
                wait_out(k, 0, lat);
                e = exp_q.pop_front();
                total++; if (lat != (32 >> k) + 1) begin bad++; $display("FAIL rand_latency k=%0d got %0d want %0d", k, lat, (32 >> k) + 1); end
                total++; if (res[k] !== e.res)  begin bad++; $display("FAIL rand_result k=%0d op=%0d a=%h b=%h got %h want %h", k, o, x, y, res[k], e.res); end
                total++; if (wrd[k] !== e.word) begin bad++; $display("FAIL rand_word k=%0d op=%0d a=%h b=%h got %h want %h", k, o, x, y, wrd[k], e.word); end
                @(posedge clk); #1;
                total++; if (ov[k] !== 1'b0)   begin bad++; $display("FAIL rand_pulse k=%0d got %b want 0", k, ov[k]); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0; op[k] = 2'b00; a[k] = 32'h0; b[k] = 32'h0;
        end
        test_reset();
        test_modes();
        test_bpc4();
        test_ignore_b2b();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
